// File: rtl/fifo_pkg.sv
// Shared definitions for the async-FIFO read-side stream stage: default width,
// occupancy state encoding and the read-credit check.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_PART  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // A new read may launch only if every word already owed to the buffer still fits.
    function automatic logic credit_ok(input int occ, input int inflight,
                                       input int pop, input int depth);
        return (occ + inflight - pop) < depth;
    endfunction

    function automatic logic [1:0] occ_state(input int occ, input int depth);
        if (occ == 0)
            return ST_EMPTY;
        else if (occ >= depth)
            return ST_FULL;
        return ST_PART;
    endfunction

endpackage

// File: rtl/skid_buf.sv
// Circular skid buffer with push/pop and an occupancy count; head entry is
// presented combinationally so the stream output needs no extra cycle.
module skid_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  occ
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  occ_reg;

    // Wraps modulo DEPTH, so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_reg[i] <= '0;
        end else if (push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push, pop})
                2'b10:   occ_reg <= occ_reg + CNT_W'(1);
                2'b01:   occ_reg <= occ_reg - CNT_W'(1);
                default: occ_reg <= occ_reg;
            endcase
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign occ       = occ_reg;

endmodule

// File: rtl/fifo_rd_stream.sv
// Turns the async FIFO's pop interface (1-cycle registered read) into a
// valid/ready stream. Optional counters: define FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SKID_DEPTH = 2,
    parameter int CNT_W      = 2
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              rempty,
    output logic              rinc,
    input  logic [DATA_W-1:0] rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  occ
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [31:0]       word_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    logic inflight_reg;
    logic pop;
    logic [1:0] occ_st;

    assign m_valid = (occ != '0);
    assign pop     = m_valid & m_ready;

    // Counting this cycle's pop as freed space lets reads resume on the first pop.
    assign rinc = !rempty && !rrst &&
                  credit_ok(int'(occ), int'(inflight_reg), int'(pop), SKID_DEPTH);

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst)
            inflight_reg <= 1'b0;
        else
            inflight_reg <= rinc;
    end

    skid_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (SKID_DEPTH),
        .CNT_W  (CNT_W)
    ) u_skid (
        .clk       (rclk),
        .rst       (rrst),
        .push      (inflight_reg),
        .push_data (rdata),
        .pop       (pop),
        .head_data (m_data),
        .occ       (occ)
    );

    assign occ_st = occ_state(int'(occ), SKID_DEPTH);

    assert property (@(posedge rclk) disable iff (rrst)
        (int'(occ) + int'(inflight_reg)) <= SKID_DEPTH);
    assert property (@(posedge rclk) disable iff (rrst)
        !(occ_st == ST_FULL && inflight_reg));

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] word_cnt_reg;
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            word_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (pop && word_cnt_reg != '1)
                word_cnt_reg <= word_cnt_reg + 32'd1;
            if (m_valid && !m_ready && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign word_cnt  = word_cnt_reg;
    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized bench for fifo_rd_stream: a queue-based FIFO plus a queue model
// of the stream buffer predict every output each cycle.
module tb_fifo_rd_stream;

    localparam int DW    = 8;
    localparam int DEPTH = 2;
    localparam int CW    = 2;

    logic          rclk = 1'b0;
    logic          rrst = 1'b1;
    logic          rempty = 1'b1;
    logic          m_ready = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          rinc;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [CW-1:0] occ;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0]   word_cnt;
    logic [31:0]   stall_cnt;
`endif

    always #5 rclk = ~rclk;

    fifo_rd_stream #(
        .DATA_W     (DW),
        .SKID_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rempty    (rempty),
        .rinc      (rinc),
        .rdata     (rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .occ       (occ)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .word_cnt  (word_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    int n_err = 0;
    int n_chk = 0;

    logic [DW-1:0] fifo_q[$];   // words waiting inside the upstream FIFO
    logic [DW-1:0] buf_q[$];    // words the stream stage should be holding
    int            mdl_inflight = 0;
    int            mdl_words = 0;
    int            mdl_stalls = 0;
    bit            hold_empty = 1'b0;

    logic          o_rinc;
    logic          o_valid;
    logic [DW-1:0] o_data;
    int            o_occ;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One rclk period: drive inputs, predict and compare outputs, then advance the models.
    task automatic cycle(input logic rdy);
        bit e_valid;
        bit e_pop;
        bit e_rinc;
        @(negedge rclk);
        m_ready = rdy;
        rempty  = (fifo_q.size() == 0) || hold_empty;
        #1;
        e_valid = (buf_q.size() != 0);
        e_pop   = e_valid && rdy;
        e_rinc  = !rempty && !rrst &&
                  ((buf_q.size() + mdl_inflight - int'(e_pop)) < DEPTH);
        o_rinc  = rinc;
        o_valid = m_valid;
        o_data  = m_data;
        o_occ   = int'(occ);
        check("rinc", 32'(rinc), 32'(e_rinc));
        check("m_valid", 32'(m_valid), 32'(e_valid));
        check("occ", 32'(o_occ), buf_q.size());
        if (e_valid)
            check("m_data", 32'(m_data), 32'(buf_q[0]));
        @(posedge rclk);
        #1;
        if (e_pop) begin
            void'(buf_q.pop_front());
            mdl_words++;
        end
        if (e_valid && !rdy)
            mdl_stalls++;
        if (mdl_inflight != 0)
            buf_q.push_back(rdata);
        mdl_inflight = int'(e_rinc);
        if (o_rinc) begin
            check("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
            if (fifo_q.size() != 0)
                rdata = fifo_q.pop_front();
        end
    endtask

    initial begin
        int first;
        int last;
        int cnt;
        int k;
        int max_occ;
        bit reached;

        // Reset held with data waiting: nothing may be popped or presented.
        for (int i = 1; i <= 16; i++)
            fifo_q.push_back(8'(i));
        repeat (3) cycle(1'b1);
        rrst = 1'b0;

        // Streaming at full rate.
        first = -1;
        last  = -1;
        cnt   = 0;
        for (int i = 0; i < 24; i++) begin
            cycle(1'b1);
            if (i == 0)
                check("rinc_after_rst", 32'(o_rinc), 32'd1);
            if (o_valid) begin
                if (first < 0)
                    first = i;
                last = i;
                cnt++;
                check("stream_seq", 32'(o_data), 32'(cnt));
            end
        end
        check("stream_latency", 32'(first), 32'd2);
        check("stream_cnt", 32'(cnt), 32'd16);
        check("stream_gapless", 32'(last - first + 1), 32'd16);

        // Back-pressure: only DEPTH reads may launch while the sink stalls.
        for (int i = 0; i < 8; i++)
            fifo_q.push_back(8'(8'h20 + i));
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0);
            if (o_rinc)
                cnt++;
        end
        check("bp_rinc_pulses", 32'(cnt), 32'd2);
        check("bp_occ", 32'(o_occ), 32'd2);
        check("bp_rinc_off", 32'(o_rinc), 32'd0);
        check("bp_head", 32'(o_data), 32'h20);
        k = 0;
        max_occ = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1);
            if (o_occ > max_occ)
                max_occ = o_occ;
            if (o_valid) begin
                check("bp_seq", 32'(o_data), 32'(8'h20 + k));
                k++;
            end
        end
        check("bp_words", 32'(k), 32'd8);
        check("bp_max_occ_ok", 32'(max_occ <= DEPTH), 32'd1);

        // Empty race: a single word is delivered exactly once.
        fifo_q.push_back(8'h55);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1);
            if (o_valid)
                cnt++;
        end
        check("race_once", 32'(cnt), 32'd1);
        check("race_valid_off", 32'(o_valid), 32'd0);
        check("race_rinc_off", 32'(o_rinc), 32'd0);

        // Mid-stream reset with a word in flight and one buffered.
        for (int i = 0; i < 8; i++)
            fifo_q.push_back(8'(8'h30 + i));
        reached = 1'b0;
        for (int i = 0; i < 10 && !reached; i++) begin
            cycle(1'b1);
            reached = (mdl_inflight == 1) && (buf_q.size() >= 1);
        end
        check("rst_setup", 32'(reached), 32'd1);
        #2;
        rrst = 1'b1;
        #1;
        check("rst_async_occ", 32'(occ), 32'd0);
        check("rst_async_valid", 32'(m_valid), 32'd0);
        check("rst_async_rinc", 32'(rinc), 32'd0);
        buf_q.delete();
        fifo_q.delete();
        mdl_inflight = 0;
        mdl_words = 0;
        mdl_stalls = 0;
        cycle(1'b1);
        rrst = 1'b0;
        for (int i = 0; i < 4; i++)
            fifo_q.push_back(8'(8'hA0 + i));
        k = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1);
            if (o_valid) begin
                check("rst_seq", 32'(o_data), 32'(8'hA0 + k));
                k++;
            end
        end
        check("rst_words", 32'(k), 32'd4);

        // Randomized traffic and back-pressure.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0 && fifo_q.size() < 16)
                fifo_q.push_back(8'($urandom));
            hold_empty = ($urandom_range(7) == 0);
            cycle(1'($urandom_range(1)));
        end
        hold_empty = 1'b0;
        for (int i = 0; i < 40; i++)
            cycle(1'b1);
        check("final_drained", 32'(o_valid), 32'd0);

`ifdef FIFO_RD_STREAM_STATS_EN
        check("word_cnt", word_cnt, 32'(mdl_words));
        check("stall_cnt", stall_cnt, 32'(mdl_stalls));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
